// File: rtl/ctrl_sequencer_if.sv
// ----------------------------------------------------------------------------
// ctrl_sequencer_if
//
// Bundles the control sequencer's datapath-facing signals so the sequencer
// and the datapath connect through a single port each.
//
//   master (sequencer side):
//     in  : ir_out  - instruction register contents
//           mfc     - memory function complete
//     out : reg_out/reg_en, io_out/io_en       - one-hot drive/load strobes
//           pc_out, pc_inc, mar_en, ir_en      - PC / MAR / IR strobes
//           mem_en, rw, mem_bus, bus_mem, mdr_out - memory / MDR strobes
//           a_in, b_in, alu_out_en, alu_sel    - ALU control
//           bus_drv, bus_drv_en                - immediate value onto the bus
//           instr_done, illegal, bus_err       - single-cycle status pulses
//   slave (datapath side): the same signals with directions reversed.
// ----------------------------------------------------------------------------
interface ctrl_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int NIO    = 2
);
    logic [DATA_W-1:0] ir_out;
    logic              mfc;

    logic [NREG-1:0]   reg_out;
    logic [NREG-1:0]   reg_en;
    logic [NIO-1:0]    io_out;
    logic [NIO-1:0]    io_en;

    logic              pc_out;
    logic              pc_inc;
    logic              mar_en;
    logic              ir_en;

    logic              mem_en;
    logic              rw;
    logic              mem_bus;
    logic              bus_mem;
    logic              mdr_out;

    logic              a_in;
    logic              b_in;
    logic              alu_out_en;
    logic [2:0]        alu_sel;

    logic [DATA_W-1:0] bus_drv;
    logic              bus_drv_en;

    logic              instr_done;
    logic              illegal;
    logic              bus_err;

    modport master (
        input  ir_out, mfc,
        output reg_out, reg_en, io_out, io_en,
               pc_out, pc_inc, mar_en, ir_en,
               mem_en, rw, mem_bus, bus_mem, mdr_out,
               a_in, b_in, alu_out_en, alu_sel,
               bus_drv, bus_drv_en,
               instr_done, illegal, bus_err
    );

    modport slave (
        output ir_out, mfc,
        input  reg_out, reg_en, io_out, io_en,
               pc_out, pc_inc, mar_en, ir_en,
               mem_en, rw, mem_bus, bus_mem, mdr_out,
               a_in, b_in, alu_out_en, alu_sel,
               bus_drv, bus_drv_en,
               instr_done, illegal, bus_err
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ----------------------------------------------------------------------------
// ctrl_sequencer
//
// Multicycle control sequencer for the 16-bit datapath. One FSM fetches,
// decodes and executes one instruction at a time and drives every datapath
// strobe through the bus interface.
//
// Ports:
//   clk    in  clock
//   reset  in  asynchronous, active-high reset
//   bus    ctrl_sequencer_if.master - ir_out/mfc in, all strobes out
//
// Instruction word: [15:12] opcode, [11:6] field A, [5:0] field B.
// A field value v selects reg[v] when v < NREG, io[v-NREG] when
// NREG <= v < NREG+NIO, and is illegal otherwise.
//
// Outputs are decoded from the state register and instr_q (plus ir_out in
// DEC and mfc in the wait states). A dedicated post-reset state keeps every
// output low during reset; the first state after release is F0.
// ----------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NREG        = 4,
    parameter int NIO         = 2,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    ctrl_sequencer_if.master     bus
);

    localparam int NSEL  = NREG + NIO;
    localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);

    localparam logic [3:0] OP_MOV   = 4'h0;
    localparam logic [3:0] OP_MOVI  = 4'hA;
    localparam logic [3:0] OP_LOAD  = 4'hB;
    localparam logic [3:0] OP_STORE = 4'hC;
    localparam logic [3:0] OP_LAST  = 4'hC;

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_DEC,
        S_MV,   S_XA, S_XB, S_XW, S_MI,
        S_LA,   S_LW, S_LX,
        S_SA,   S_SD, S_SW
    } state_t;

    typedef struct packed {
        logic       pc_out;
        logic       pc_inc;
        logic       mar_en;
        logic       ir_en;
        logic       mem_en;
        logic       rw;
        logic       mem_bus;
        logic       bus_mem;
        logic       mdr_out;
        logic       a_in;
        logic       b_in;
        logic       alu_out_en;
        logic [2:0] alu_sel;
        logic       bus_drv_en;
        logic       instr_done;
        logic       illegal;
        logic       bus_err;
    } strobe_t;

    state_t            state;
    logic [DATA_W-1:0] instr_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wait_last;

    strobe_t           s;
    logic [NSEL-1:0]   drv_sel;
    logic [NSEL-1:0]   ld_sel;

    logic [3:0]        op_q;
    logic [5:0]        fld_a;
    logic [5:0]        fld_b;

    assign op_q      = instr_q[15:12];
    assign fld_a     = instr_q[11:6];
    assign fld_b     = instr_q[5:0];
    assign wait_last = (wait_cnt == CNT_W'(MFC_TIMEOUT - 1));

    function automatic logic field_ok(input logic [5:0] v);
        return int'(v) < NSEL;
    endfunction

    // One-hot over the combined register/IO space; an out-of-range value
    // yields all zeros.
    function automatic logic [NSEL-1:0] field_sel(input logic [5:0] v);
        logic [NSEL-1:0] r;
        r = '0;
        for (int i = 0; i < NSEL; i++) r[i] = (int'(v) == i);
        return r;
    endfunction

    // MOVI only uses field A; every other opcode uses both fields, even the
    // ALU-immediate forms whose B field is the immediate value.
    function automatic logic dec_illegal(input logic [DATA_W-1:0] ir);
        logic [3:0] op;
        op = ir[15:12];
        if (op > OP_LAST)  return 1'b1;
        if (op == OP_MOVI) return !field_ok(ir[11:6]);
        return !field_ok(ir[11:6]) || !field_ok(ir[5:0]);
    endfunction

    function automatic logic [2:0] alu_func(input logic [3:0] op);
        case (op)
            4'h1, 4'h2: return 3'b000;
            4'h3, 4'h4: return 3'b001;
            4'h6:       return 3'b010;
            4'h7:       return 3'b011;
            4'h8:       return 3'b100;
            4'h5:       return 3'b101;
            4'h9:       return 3'b110;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic is_alu_imm(input logic [3:0] op);
        return (op == 4'h2) || (op == 4'h4);
    endfunction

    // ------------------------------------------------------------------------
    // State register, captured instruction and wait counter
    // ------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments under an
    // asynchronous reset so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            wait_cnt <= '0;
        end else begin
            // Cleared everywhere except while staying in a wait state, so
            // it is zero on entry to F1, LW and SW.
            wait_cnt <= '0;
            case (state)
                S_IDLE: state <= S_F0;
                S_F0:   state <= S_F1;
                S_F1: begin
                    if (bus.mfc)        state <= S_F2;
                    else if (wait_last) state <= S_F0;
                    else                wait_cnt <= wait_cnt + 1'b1;
                end
                S_F2:   state <= S_DEC;
                S_DEC: begin
                    instr_q <= bus.ir_out;
                    if (dec_illegal(bus.ir_out)) begin
                        state <= S_F0;
                    end else begin
                        case (bus.ir_out[15:12])
                            OP_MOV:   state <= S_MV;
                            OP_MOVI:  state <= S_MI;
                            OP_LOAD:  state <= S_LA;
                            OP_STORE: state <= S_SA;
                            default:  state <= S_XA;
                        endcase
                    end
                end
                S_XA:   state <= S_XB;
                S_XB:   state <= S_XW;
                S_LA:   state <= S_LW;
                S_LW: begin
                    if (bus.mfc)        state <= S_LX;
                    else if (wait_last) state <= S_F0;
                    else                wait_cnt <= wait_cnt + 1'b1;
                end
                S_SA:   state <= S_SD;
                S_SD:   state <= S_SW;
                S_SW: begin
                    if (bus.mfc || wait_last) state <= S_F0;
                    else                      wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= S_F0;   // MV, MI, XW, LX
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        s       = '0;
        drv_sel = '0;
        ld_sel  = '0;
        case (state)
            S_F0: begin
                s.pc_out = 1'b1;
                s.mar_en = 1'b1;
            end
            S_F1: begin
                s.mem_en  = 1'b1;
                s.rw      = 1'b1;
                s.bus_err = !bus.mfc && wait_last;
            end
            S_F2: begin
                s.mem_bus = 1'b1;
                s.mdr_out = 1'b1;
                s.ir_en   = 1'b1;
                s.pc_inc  = 1'b1;
            end
            S_DEC: s.illegal = dec_illegal(bus.ir_out);
            S_MV: begin
                drv_sel      = field_sel(fld_b);
                ld_sel       = field_sel(fld_a);
                s.instr_done = 1'b1;
            end
            S_XA: begin
                drv_sel   = field_sel(fld_a);
                s.a_in    = 1'b1;
                s.alu_sel = alu_func(op_q);
            end
            S_XB: begin
                if (is_alu_imm(op_q)) s.bus_drv_en = 1'b1;
                else                  drv_sel      = field_sel(fld_b);
                s.b_in    = 1'b1;
                s.alu_sel = alu_func(op_q);
            end
            S_XW: begin
                s.alu_out_en = 1'b1;
                ld_sel       = field_sel(fld_a);
                s.instr_done = 1'b1;
                s.alu_sel    = alu_func(op_q);
            end
            S_MI: begin
                s.bus_drv_en = 1'b1;
                ld_sel       = field_sel(fld_a);
                s.instr_done = 1'b1;
            end
            S_LA, S_SA: begin
                drv_sel  = field_sel(fld_a);
                s.mar_en = 1'b1;
            end
            S_LW: begin
                s.mem_en  = 1'b1;
                s.rw      = 1'b1;
                s.bus_err = !bus.mfc && wait_last;
            end
            S_LX: begin
                s.mdr_out    = 1'b1;
                s.mem_bus    = 1'b1;
                ld_sel       = field_sel(fld_b);
                s.instr_done = 1'b1;
            end
            S_SD: begin
                drv_sel   = field_sel(fld_b);
                s.bus_mem = 1'b1;
            end
            S_SW: begin
                s.mem_en     = 1'b1;
                s.instr_done = bus.mfc;
                s.bus_err    = !bus.mfc && wait_last;
            end
            default: ;   // S_IDLE: everything low
        endcase
    end

    assign bus.reg_out    = drv_sel[NREG-1:0];
    assign bus.reg_en     = ld_sel[NREG-1:0];
    assign bus.io_out     = drv_sel[NSEL-1:NREG];
    assign bus.io_en      = ld_sel[NSEL-1:NREG];
    assign bus.pc_out     = s.pc_out;
    assign bus.pc_inc     = s.pc_inc;
    assign bus.mar_en     = s.mar_en;
    assign bus.ir_en      = s.ir_en;
    assign bus.mem_en     = s.mem_en;
    assign bus.rw         = s.rw;
    assign bus.mem_bus    = s.mem_bus;
    assign bus.bus_mem    = s.bus_mem;
    assign bus.mdr_out    = s.mdr_out;
    assign bus.a_in       = s.a_in;
    assign bus.b_in       = s.b_in;
    assign bus.alu_out_en = s.alu_out_en;
    assign bus.alu_sel    = s.alu_sel;
    assign bus.bus_drv_en = s.bus_drv_en;
    // Immediate is field B zero-extended, shown only while it is valid.
    assign bus.bus_drv    = s.bus_drv_en ? {{(DATA_W-6){1'b0}}, fld_b} : '0;
    assign bus.instr_done = s.instr_done;
    assign bus.illegal    = s.illegal;
    assign bus.bus_err    = s.bus_err;

endmodule
